// File: rtl/inst_encoder_loader_pkg.sv
// inst_encoder_loader_pkg: class codes, ALU op codes, RV32I opcodes and encoding helpers.
package inst_encoder_loader_pkg;

   typedef enum logic [3:0] {
      CLS_R      = 4'd0,
      CLS_I_ALU  = 4'd1,
      CLS_LOAD   = 4'd2,
      CLS_JALR   = 4'd3,
      CLS_STORE  = 4'd4,
      CLS_BRANCH = 4'd5,
      CLS_LUI    = 4'd6,
      CLS_AUIPC  = 4'd7,
      CLS_JAL    = 4'd8
   } cls_t;

   typedef enum logic [3:0] {
      ALU_ADD  = 4'd0,
      ALU_SUB  = 4'd1,
      ALU_AND  = 4'd2,
      ALU_OR   = 4'd3,
      ALU_XOR  = 4'd4,
      ALU_SLL  = 4'd5,
      ALU_SRL  = 4'd6,
      ALU_SRA  = 4'd7,
      ALU_SLT  = 4'd8,
      ALU_SLTU = 4'd9
   } alu_op_t;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   localparam logic [6:0] OP_R      = 7'h33;
   localparam logic [6:0] OP_I      = 7'h13;
   localparam logic [6:0] OP_LOAD   = 7'h03;
   localparam logic [6:0] OP_JALR   = 7'h67;
   localparam logic [6:0] OP_STORE  = 7'h23;
   localparam logic [6:0] OP_BRANCH = 7'h63;
   localparam logic [6:0] OP_LUI    = 7'h37;
   localparam logic [6:0] OP_AUIPC  = 7'h17;
   localparam logic [6:0] OP_JAL    = 7'h6F;

   function automatic logic [2:0] alu_f3(input logic [3:0] op);
      logic [2:0] f;
      case (op)
         ALU_SLL:          f = 3'b001;
         ALU_SLT:          f = 3'b010;
         ALU_SLTU:         f = 3'b011;
         ALU_XOR:          f = 3'b100;
         ALU_SRL, ALU_SRA: f = 3'b101;
         ALU_OR:           f = 3'b110;
         ALU_AND:          f = 3'b111;
         default:          f = 3'b000;
      endcase
      return f;
   endfunction

   // True when v is representable as an n-bit two's-complement value.
   function automatic logic fits_s(input logic [31:0] v, input int n);
      logic [31:0] hi;
      hi = 32'($signed(v) >>> (n - 1));
      return hi == '0 || hi == '1;
   endfunction

endpackage

// File: rtl/inst_encoder_loader_encoder.sv
// inst_encoder: combinational micro-op fields to RV32I word plus illegal-input flag.
module inst_encoder
   import inst_encoder_loader_pkg::*;
(
   input  logic [3:0]  cls,
   input  logic [3:0]  alu_op,
   input  logic [2:0]  br_cond,
   input  logic [4:0]  rd,
   input  logic [4:0]  rs1,
   input  logic [4:0]  rs2,
   input  logic [31:0] imm,
   output logic [31:0] word,
   output logic        illegal
);

   logic [2:0] f3;
   logic [6:0] f7;
   logic       is_sh;
   logic       bad_op;

   assign f3     = alu_f3(alu_op);
   assign is_sh  = alu_op == ALU_SLL || alu_op == ALU_SRL || alu_op == ALU_SRA;
   assign f7     = (alu_op == ALU_SUB || alu_op == ALU_SRA) ? 7'h20 : 7'h00;
   assign bad_op = alu_op > ALU_SLTU;

   always_comb begin
      word    = '0;
      illegal = 1'b0;
      case (cls)
         CLS_R: begin
            word    = {f7, rs2, rs1, f3, rd, OP_R};
            illegal = bad_op;
         end
         CLS_I_ALU: begin
            word    = is_sh ? {f7, imm[4:0], rs1, f3, rd, OP_I} : {imm[11:0], rs1, f3, rd, OP_I};
            illegal = bad_op | (alu_op == ALU_SUB) | (is_sh ? imm > 32'd31 : !fits_s(imm, 12));
         end
         CLS_LOAD: begin
            word    = {imm[11:0], rs1, 3'b010, rd, OP_LOAD};
            illegal = !fits_s(imm, 12);
         end
         CLS_JALR: begin
            word    = {imm[11:0], rs1, 3'b000, rd, OP_JALR};
            illegal = !fits_s(imm, 12);
         end
         CLS_STORE: begin
            word    = {imm[11:5], rs2, rs1, 3'b010, imm[4:0], OP_STORE};
            illegal = !fits_s(imm, 12);
         end
         CLS_BRANCH: begin
            word    = {imm[12], imm[10:5], rs2, rs1, br_cond, imm[4:1], imm[11], OP_BRANCH};
            illegal = !fits_s(imm, 13) | imm[0];
         end
         CLS_LUI: begin
            word    = {imm[31:12], rd, OP_LUI};
            illegal = imm[11:0] != 12'd0;
         end
         CLS_AUIPC: begin
            word    = {imm[31:12], rd, OP_AUIPC};
            illegal = imm[11:0] != 12'd0;
         end
         CLS_JAL: begin
            word    = {imm[20], imm[10:1], imm[11], imm[19:12], rd, OP_JAL};
            illegal = !fits_s(imm, 21) | imm[0];
         end
         default: illegal = 1'b1;
      endcase
   end

endmodule

// File: rtl/inst_encoder_loader.sv
// inst_encoder_loader: encodes a micro-op stream into RV32I words and writes them to IROM.
module inst_encoder_loader
   import inst_encoder_loader_pkg::*;
#(
   parameter int ADDR_W = 12,
   parameter int DEPTH  = 4096,
   parameter int BASE   = 0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic              in_last,
   input  logic [3:0]        in_cls,
   input  logic [3:0]        in_alu_op,
   input  logic [2:0]        in_br_cond,
   input  logic [4:0]        in_rd,
   input  logic [4:0]        in_rs1,
   input  logic [4:0]        in_rs2,
   input  logic [31:0]       in_imm,
   output logic              wr_en,
   input  logic              wr_ready,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [31:0]       wr_data,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic [ADDR_W:0]   wr_count
);

   localparam logic [ADDR_W:0]   DEPTH_C = (ADDR_W + 1)'(DEPTH);
   localparam logic [ADDR_W-1:0] BASE_C  = ADDR_W'(BASE);

   state_t          state;
   state_t          state_n;
   logic [31:0]     enc_word;
   logic            enc_bad;
   logic [ADDR_W:0] accepted;
   logic            last_seen;
   logic            wr_last;
   logic            ill_last;
   logic            acc;
   logic            retire;
   logic            launch;
   logic            finish;

   inst_encoder u_enc (
      .cls     (in_cls),
      .alu_op  (in_alu_op),
      .br_cond (in_br_cond),
      .rd      (in_rd),
      .rs1     (in_rs1),
      .rs2     (in_rs2),
      .imm     (in_imm),
      .word    (enc_word),
      .illegal (enc_bad)
   );

   assign busy     = state == ST_LOAD;
   assign done     = state == ST_DONE;
   assign in_ready = busy & (!wr_en | wr_ready) & !last_seen & (accepted < DEPTH_C);
   assign acc      = in_valid & in_ready;
   assign retire   = wr_en & wr_ready;
   assign launch   = start & !busy;
   // An illegal final beat has no write to wait for, so it finishes via ill_last.
   assign finish   = ill_last | (retire & (wr_last | wr_count == DEPTH_C - 1'b1));

   always_ff @(posedge clk) begin
      state <= rst ? ST_IDLE : state_n;
   end

   always_comb begin
      state_n = state;
      state_n = launch ? ST_LOAD : (busy & finish) ? ST_DONE : state;
   end

   always_ff @(posedge clk) begin
      if (rst || launch) begin
         wr_en     <= 1'b0;
         wr_addr   <= BASE_C;
         wr_data   <= '0;
         wr_count  <= '0;
         err       <= 1'b0;
         accepted  <= '0;
         last_seen <= 1'b0;
         wr_last   <= 1'b0;
         ill_last  <= 1'b0;
      end else begin
         ill_last <= acc & enc_bad & in_last;
         if (retire) begin
            wr_en    <= 1'b0;
            wr_addr  <= wr_addr + 1'b1;
            wr_count <= wr_count + 1'b1;
         end
         if (acc) begin
            last_seen <= in_last;
            err       <= err | enc_bad;
            if (!enc_bad) begin
               wr_en    <= 1'b1;
               wr_data  <= enc_word;
               wr_last  <= in_last;
               accepted <= accepted + 1'b1;
            end
         end
      end
   end

endmodule

// File: doc/inst_encoder_loader.md
Name: inst_encoder_loader

Overview:
- Encoder counterpart of the control-unit decoder: takes decoded micro-op fields (class, ALU op, branch condition, register indices, immediate) over a valid/ready stream and assembles legal RV32I instruction words.
- Writes the words sequentially into the IROM write port, handling memory back-pressure.
- Sits between the trace/self-test sequencer and instruction memory, so the single-cycle CPU can run generated programs.

Parameters:
- ADDR_W, 12, IROM word-address width.
- DEPTH, 4096, maximum words per load; must satisfy DEPTH <= 2**ADDR_W.
- BASE, 0, first word address written.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- start  in  1  pulse: begin a load
- in_valid  in  1  micro-op valid
- in_ready  out  1  micro-op accepted when in_valid & in_ready
- in_last  in  1  final micro-op of the program
- in_cls  in  4  0 R, 1 I_ALU, 2 LOAD, 3 JALR, 4 STORE, 5 BRANCH, 6 LUI, 7 AUIPC, 8 JAL
- in_alu_op  in  4  shared ALU op code (ADD, SUB, AND, OR, XOR, SLL, SRL, SRA, SLT, SLTU)
- in_br_cond  in  3  branch funct3
- in_rd, in_rs1, in_rs2  in  5 each  register indices
- in_imm  in  32  byte-offset or value immediate; LUI/AUIPC take the full value with bits [11:0] = 0
- wr_en  out  1  IROM write request
- wr_ready  in  1  IROM accepts the write
- wr_addr  out  ADDR_W  word address
- wr_data  out  32  instruction word
- busy  out  1  state == LOAD
- done  out  1  state == DONE
- err  out  1  sticky illegal-input flag
- wr_count  out  ADDR_W+1  words written this load

Behaviour:
- Reset: state IDLE; all outputs 0; wr_addr = BASE.
- States and transitions:
  - IDLE: start -> LOAD; clear wr_count and err; wr_addr = BASE.
  - LOAD: load in progress (see below).
  - DONE: start -> LOAD (restart).
  - start is ignored while in LOAD.
- Accepting input: in_ready = busy & (!wr_en | wr_ready) & !last_seen & (accepted < DEPTH).
- Encoding: purely combinational from the input fields; the word is registered into a single output slot on accept.
  - Latency: accept in cycle N, wr_en high from cycle N+1.
- Write handshake:
  - wr_en, wr_addr and wr_data are held stable until wr_en & wr_ready.
  - On that cycle wr_addr and wr_count increment.
  - Accept and retire in the same cycle is allowed, giving full throughput.
- Encoding rules:
  - R: opcode 0x33; funct7 = 0x20 for SUB/SRA, else 0x00.
  - I_ALU: opcode 0x13; shifts use imm[4:0] with funct7 in [31:25].
  - LOAD/STORE: word only, funct3 = 010.
  - BRANCH: imm[12:1] scattered per B-format.
  - JAL: imm[20:1] scattered per J-format.
  - JALR: funct3 = 000.
- Illegal input: SUB in I_ALU; shift immediate > 31; immediate out of signed range (I/S: 12-bit, B: 13-bit, J: 21-bit); B/J immediate odd; LUI/AUIPC imm[11:0] != 0; cls > 8.
  - The beat is still accepted, but nothing is written and err is set (sticky until the next start).
- LOAD -> DONE when either:
  - the write carrying in_last retires, or
  - wr_count reaches DEPTH.
- An illegal in_last beat goes to DONE one cycle after it is accepted.
- DEPTH boundary: in_ready stays low once DEPTH words have been accepted; no wrap-around.
- Reset mid-load: the pending write is dropped and wr_en falls in the next cycle.

Decomposition:
- Shared package holds:
  - the class codes;
  - the existing ALU op codes, reused and not redefined;
  - the RV32I opcode constants (0x33, 0x13, 0x03, 0x67, 0x23, 0x63, 0x37, 0x17, 0x6F).
- Sub-module inst_encoder: combinational fields -> {word, illegal}; reusable by the verification model.

Test Plan:
- start, then addi x1,x0,5 (cls 1, ADD, imm 5), wr_ready = 1 -> one cycle later wr_en, wr_addr = 0, wr_data = 0x00500093.
- add x3,x1,x2 then sub x3,x1,x2 back-to-back -> 0x002081B3 at addr 0, 0x402081B3 at addr 1, in consecutive cycles.
- beq x1,x2,+8; jal x1,+16; lui x5 with imm 0x12345000; sw x2,4(x1) with in_last on the final beat -> 0x00208463, 0x010000EF, 0x123452B7, 0x0020A223; done rises after the 4th write; wr_count = 4.
- wr_ready held 0 for 3 cycles with in_valid high -> wr_en/addr/data stay stable, in_ready = 0, no words lost.
- branch with imm = 7 -> err = 1, no write, wr_count unchanged; the next legal beat is still written at the same address.
- DEPTH = 4 stream of 6 beats without in_last -> 4 writes, done, in_ready stays 0; rst asserted mid-load -> everything cleared next cycle.
